mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: TIMEOUT, 255, maximum cycles bus_req waits for bus_ack before abort (1..65535).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  one-cycle request strobe from controller.
REQ-005 memwrite  input  2  store size: 00 none, 01 byte, 10 half, 11 word.
REQ-006 loadsize  input  3  load type: 010 LB, 100 LH, 001 LBU, 011 LHU, 101 LW, other none.
REQ-007 addr  input  32  byte address of access.
REQ-008 wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-009 rdata  output  32  extended load result.
REQ-010 busy  output  1  high whenever FSM is not IDLE.
REQ-011 done  output  1  one-cycle pulse on completion (success or error).
REQ-012 err  output  1  qualifies done: misaligned, conflicting, or timed-out access.
REQ-013 bus_req  output  1  bus cycle request.
REQ-014 bus_we  output  1  bus write enable.
REQ-015 bus_be  output  4  byte lane enables, lane i = bits [8i+7:8i].
REQ-016 bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-017 bus_wdata  output  32  store data replicated into the selected lanes.
REQ-018 bus_rdata  input  32  bus read data, valid when bus_ack high.
REQ-019 bus_ack  input  1  bus completion, sampled while bus_req high.

Function
REQ-020 FSM states SHALL be IDLE, BUS, DONE, ERR.
REQ-021 In IDLE, start with a valid store (memwrite!=00, loadsize invalid) or valid load (memwrite==00, loadsize valid) SHALL latch addr/wdata/size and move to BUS.
REQ-022 start in IDLE with memwrite!=00 and loadsize valid, or a misaligned access (half with addr[0]=1, word with addr[1:0]!=00), SHALL move to ERR without asserting bus_req.
REQ-023 start in IDLE with memwrite==00 and loadsize invalid SHALL be ignored; start outside IDLE SHALL be ignored.
REQ-024 bus_req, bus_we, bus_be, bus_addr, bus_wdata SHALL be registered: asserted the cycle after accepted start and held stable until bus_ack sampled high.
REQ-025 bus_be SHALL be 0001<<addr[1:0] for byte, 0011<<addr[1:0] for half, 1111 for word; bus_wdata SHALL replicate byte in all four lanes and half in both halves.
REQ-026 bus_ack sampled high in BUS SHALL move to DONE; bus_req SHALL deassert next cycle; bus_ack outside BUS SHALL be ignored.
REQ-027 On load ack, rdata SHALL take the addressed byte/half (little-endian lane select), sign-extended for LB/LH, zero-extended for LBU/LHU, unmodified for LW.
REQ-028 rdata SHALL hold its value until the next completed load; stores and errors SHALL not alter rdata.
REQ-029 A 16-bit wait counter SHALL clear on entry to BUS and increment each BUS cycle without ack; reaching TIMEOUT SHALL deassert bus_req and move to ERR.
REQ-030 DONE SHALL last one cycle with done=1, err=0, then IDLE; ERR SHALL last one cycle with done=1, err=1, then IDLE.
REQ-031 busy SHALL be high in BUS, DONE, ERR; a new start is accepted the cycle after done.
REQ-032 Minimum load/store latency: start at cycle N, bus_req N+1, ack at N+1, done at N+2.

Reset
REQ-033 reset SHALL force IDLE and clear rdata, busy, done, err, bus_req, bus_we, bus_be, bus_addr, bus_wdata, wait counter to zero on the next edge.
REQ-034 reset during BUS SHALL drop bus_req next cycle and produce no done pulse.

Verification
REQ-035 LB addr=0x1003, bus_rdata=0x80FF_FF7F, ack one cycle after req -> bus_be=1000, bus_addr=0x1000, rdata=0xFFFF_FF80, done at N+2, err=0.
REQ-036 SH addr=0x2002, wdata=0x0000_BEEF, ack after 3 wait cycles -> bus_we=1, bus_be=1100, bus_wdata=0xBEEF_BEEF, stable 4 cycles, done, err=0.
REQ-037 LW addr=0x3001 -> no bus_req, done=1 err=1 at N+1; same for memwrite=11 with loadsize=101 at aligned address.
REQ-038 TIMEOUT=4, LHU with bus_ack held low -> bus_req high exactly 4 cycles, then done=1 err=1, rdata unchanged.
REQ-039 reset asserted while bus_req high and start pulsed while busy -> bus_req low next cycle, no done, all outputs zero; ignored start produces no bus cycle.

Source files
------------

// File: rtl/mem_access_unit.sv
// Load/store bus master: validates, aligns and issues one bus cycle per
// request; ports: clk/reset/start, access controls, rdata/busy/done/err, bus.
module mem_access_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  memwrite,
  input  logic [2:0]  loadsize,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, BUS, DONE, ERR} state_t;

  localparam logic [15:0] TO = 16'(TIMEOUT);

  state_t      state;
  logic [15:0] wait_cnt;
  logic [1:0]  lat_size;
  logic        lat_sgn;
  logic        lat_load;
  logic [1:0]  lat_off;

  // size code: 01 byte, 10 half, 11 word
  logic        ld_ok;
  logic        ld_sgn;
  logic [1:0]  ld_size;
  logic [1:0]  acc_size;
  logic        misalign;
  logic        conflict;
  logic        accept;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  always_comb begin
    ld_ok   = 1'b1;
    ld_sgn  = 1'b0;
    ld_size = 2'b00;
    case (loadsize)
      3'b010: begin ld_size = 2'b01; ld_sgn = 1'b1; end
      3'b100: begin ld_size = 2'b10; ld_sgn = 1'b1; end
      3'b001: ld_size = 2'b01;
      3'b011: ld_size = 2'b10;
      3'b101: ld_size = 2'b11;
      default: ld_ok = 1'b0;
    endcase
  end

  always_comb begin
    acc_size = (memwrite != 2'b00) ? memwrite : ld_size;
    misalign = (acc_size == 2'b10 && addr[0]) ||
               (acc_size == 2'b11 && addr[1:0] != 2'b00);
    conflict = (memwrite != 2'b00) && ld_ok;
    accept   = (memwrite != 2'b00) || ld_ok;
    case (acc_size)
      2'b01: begin
        be_next = 4'b0001 << addr[1:0];
        wd_next = {4{wdata[7:0]}};
      end
      2'b10: begin
        be_next = 4'b0011 << addr[1:0];
        wd_next = {2{wdata[15:0]}};
      end
      default: begin
        be_next = 4'b1111;
        wd_next = wdata;
      end
    endcase
  end

  // little-endian lane select: move the addressed lane down to bit 0
  always_comb begin
    shifted = bus_rdata >> {lat_off, 3'b000};
    case (lat_size)
      2'b01:   ld_data = {{24{shifted[7] & lat_sgn}}, shifted[7:0]};
      2'b10:   ld_data = {{16{shifted[15] & lat_sgn}}, shifted[15:0]};
      default: ld_data = bus_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_be    <= '0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      wait_cnt  <= '0;
      lat_size  <= '0;
      lat_sgn   <= 1'b0;
      lat_load  <= 1'b0;
      lat_off   <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (start && accept) begin
            busy <= 1'b1;
            if (conflict || misalign) begin
              state <= ERR;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= BUS;
              bus_req   <= 1'b1;
              bus_we    <= (memwrite != 2'b00);
              bus_be    <= be_next;
              bus_addr  <= {addr[31:2], 2'b00};
              bus_wdata <= wd_next;
              wait_cnt  <= '0;
              lat_size  <= acc_size;
              lat_sgn   <= ld_sgn;
              lat_load  <= (memwrite == 2'b00);
              lat_off   <= addr[1:0];
            end
          end
        end
        BUS: begin
          if (bus_ack || wait_cnt + 16'd1 == TO) begin
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_be    <= '0;
            bus_wdata <= '0;
            done      <= 1'b1;
            if (bus_ack) begin
              state <= DONE;
              if (lat_load) rdata <= ld_data;
            end else begin
              state <= ERR;
              err   <= 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        DONE, ERR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomized bench for mem_access_unit against a
// behavioural transaction model; TIMEOUT reduced to 4 for timeout cases.
module tb_mem_access_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  memwrite;
  logic [2:0]  loadsize;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        busy;
  logic        done;
  logic        err;
  logic        bus_req;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_rdata = '0;

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start),
    .memwrite(memwrite), .loadsize(loadsize),
    .addr(addr), .wdata(wdata), .rdata(rdata),
    .busy(busy), .done(done), .err(err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // kind: 0 ignored, 1 rejected, 2 bus cycle; sz in bytes
  function automatic void model(input logic [1:0] mw, input logic [2:0] ls,
                                input logic [31:0] a, output int kind,
                                output int sz, output bit sgn);
    int lsz;
    lsz = 0;
    sgn = 0;
    case (ls)
      3'b010: begin lsz = 1; sgn = 1; end
      3'b100: begin lsz = 2; sgn = 1; end
      3'b001: lsz = 1;
      3'b011: lsz = 2;
      3'b101: lsz = 4;
      default: lsz = 0;
    endcase
    sz = (mw == 0) ? lsz : (mw == 3 ? 4 : int'(mw));
    if (mw == 0 && lsz == 0) kind = 0;
    else if (mw != 0 && lsz != 0) kind = 1;
    else if (a % sz != 0) kind = 1;
    else kind = 2;
  endfunction

  task automatic txn(input logic [1:0] mw, input logic [2:0] ls,
                     input logic [31:0] a, input logic [31:0] wd,
                     input logic [31:0] rd, input int dly,
                     input bit pulse);
    int kind, sz, i, off;
    bit sgn, acked;
    logic [31:0] ebe, ewd, v, mask, r;
    model(mw, ls, a, kind, sz, sgn);
    off = int'(a % 4);
    start = 1; memwrite = mw; loadsize = ls; addr = a; wdata = wd;
    tick();
    start = 0; memwrite = 0; loadsize = 0;
    r = $urandom; addr = r;
    r = $urandom; wdata = r;
    if (kind == 0) begin
      chk("ign_busy", busy, 0);
      chk("ign_req", bus_req, 0);
      chk("ign_done", done, 0);
      return;
    end
    if (kind == 1) begin
      chk("rej_req", bus_req, 0);
      chk("rej_done", done, 1);
      chk("rej_err", err, 1);
      chk("rej_busy", busy, 1);
      tick();
      chk("rej_done2", done, 0);
      chk("rej_busy2", busy, 0);
      chk("rej_rdata", rdata, exp_rdata);
      return;
    end
    ebe = ((32'd1 << sz) - 1) << off;
    ewd = '0;
    for (int b = 0; b < 4; b++) ewd[8*b +: 8] = wd[8*(b % sz) +: 8];
    i = 0;
    acked = 0;
    while (!acked && i < TO) begin
      chk("req", bus_req, 1);
      chk("we", bus_we, (mw != 0));
      chk("be", bus_be, ebe[3:0]);
      chk("addr", bus_addr, a & 32'hFFFF_FFFC);
      if (mw != 0) chk("wdata", bus_wdata, ewd);
      chk("bus_done", done, 0);
      if (pulse && i == 0) begin
        start = 1; memwrite = 2'b11; loadsize = 3'b000; addr = 32'h0;
      end
      if (i == dly) begin
        bus_ack = 1; bus_rdata = rd; acked = 1;
      end else begin
        r = $urandom; bus_rdata = r;
      end
      tick();
      bus_ack = 0; start = 0; memwrite = 0;
      i++;
    end
    chk("end_done", done, 1);
    chk("end_err", err, !acked);
    chk("end_req", bus_req, 0);
    chk("end_busy", busy, 1);
    if (acked && mw == 0) begin
      mask = (sz == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * sz)) - 1;
      v = (rd >> (8 * off)) & mask;
      if (sgn && sz < 4 && v[8*sz-1]) v = v - (32'd1 << (8 * sz));
      exp_rdata = v;
    end
    chk("rdata", rdata, exp_rdata);
    tick();
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_req", bus_req, 0);
  endtask

  initial begin
    logic [2:0] lsv [5];
    logic [31:0] r, a, w, d;
    logic [1:0] mw;
    logic [2:0] ls;
    lsv = '{3'b010, 3'b100, 3'b001, 3'b011, 3'b101};
    reset = 1; start = 0; memwrite = 0; loadsize = 0;
    addr = 0; wdata = 0; bus_rdata = 0; bus_ack = 0;
    tick(); tick();
    reset = 0;
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_req", bus_req, 0);
    chk("rst_be", bus_be, 0);

    // LB sign-extended from top lane
    txn(2'b00, 3'b010, 32'h1003, 32'h0, 32'h80FF_FF7F, 0, 0);
    chk("lb_val", rdata, 32'hFFFF_FF80);
    // SH with three wait cycles
    txn(2'b10, 3'b000, 32'h2002, 32'h0000_BEEF, 32'h0, 3, 0);
    // misaligned LW and conflicting store/load
    txn(2'b00, 3'b101, 32'h3001, 32'h0, 32'h0, 0, 0);
    txn(2'b11, 3'b101, 32'h3000, 32'h0, 32'h0, 0, 0);
    // LHU that times out, rdata held
    txn(2'b00, 3'b011, 32'h4002, 32'h0, 32'h1234_5678, 99, 0);
    chk("to_rdata", rdata, 32'hFFFF_FF80);
    // ignored start
    txn(2'b00, 3'b000, 32'h5000, 32'h0, 32'h0, 0, 0);
    tick();
    chk("ign_req2", bus_req, 0);
    // start while busy is ignored
    txn(2'b00, 3'b001, 32'h6001, 32'h0, 32'h0000_A500, 1, 1);
    chk("lbu_val", rdata, 32'h0000_00A5);
    tick();
    chk("busy_start_req", bus_req, 0);
    chk("busy_start_busy", busy, 0);

    // reset in the middle of a bus cycle
    start = 1; loadsize = 3'b101; addr = 32'h7000;
    tick();
    start = 0; loadsize = 0;
    chk("mid_req", bus_req, 1);
    reset = 1;
    tick();
    reset = 0;
    chk("mid_req0", bus_req, 0);
    chk("mid_done", done, 0);
    chk("mid_busy", busy, 0);
    chk("mid_rdata", rdata, 0);
    chk("mid_be", bus_be, 0);
    chk("mid_addr", bus_addr, 0);
    chk("mid_we", bus_we, 0);
    exp_rdata = 0;
    tick();
    chk("mid_done2", done, 0);
    chk("mid_err2", err, 0);

    for (int n = 0; n < 60; n++) begin
      r = $urandom;
      mw = r[1:0];
      ls = r[4:2];
      if (r[5]) ls = lsv[$urandom_range(0, 4)];
      if (mw != 0 && r[7:6] != 2'b00) ls = 3'b000;
      if (mw == 0 && r[9:8] != 2'b00) ls = lsv[$urandom_range(0, 4)];
      a = $urandom;
      if (r[10]) a[1:0] = 2'b00;
      w = $urandom;
      d = $urandom;
      txn(mw, ls, a, w, d, $urandom_range(0, 5), 0);
      r = $urandom;
      bus_ack = 1; bus_rdata = r;
      tick();
      bus_ack = 0;
      chk("idle_ack_rdata", rdata, exp_rdata);
      chk("idle_ack_done", done, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
